matrix_multi_tiled: RTL and testbench
=====================================

Name: matrix_multi_tiled

Overview:
- Parametrised NxN signed fixed-point matrix multiplier, C = A x B.
- Time-multiplexes one 2x2 block multiply-accumulate engine over all output tiles, instead of instantiating one 2x2 multiplier per tile pair.
- Adds a start/busy/done handshake, runtime fixed-point scaling with rounding, saturation, and a sticky overflow flag.
- Sits in the same matrix datapath as the fixed 4x4 block multiplier and is the scalable replacement for it.

Parameters:
- width, 16: element word is 2*width bits, signed two's complement.
- N, 4: matrix dimension. Must be even and >= 2. Tile grid is T = N/2 by N/2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- A  in  [2*width-1:0][N][N]  left operand; captured on start acceptance.
- B  in  [2*width-1:0][N][N]  right operand; captured on start acceptance.
- shift  in  5  fraction bits removed from each result (arithmetic right shift); captured on start acceptance.
- busy  out  1  high in MAC and DONE states.
- done  out  1  one-cycle pulse when all of C is valid.
- overflow  out  1  sticky; any element saturated in the current operation.
- C  out  [2*width-1:0][N][N]  registered result.

Behaviour:
- Reset (async assert, sync release): FSM to IDLE, tile counters (ti, tj, k) = 0, accumulators = 0, C = 0, busy = 0, done = 0, overflow = 0. Reset mid-operation aborts immediately; no partial C is retained.
- States and transitions:
  - IDLE: start=1 at an edge captures A, B, shift; clears overflow; zeroes ti, tj, k; goes to MAC.
  - MAC: one edge per k step. Four accumulators, one per element of tile (ti,tj), each add two products from 2x2 block A(ti,k) x B(k,tj). On the edge with k = T-1 the final sum is post-processed and written to C tile (ti,tj). The accumulators clear, k wraps to 0, and tj advances; tj wraps to 0 and advances ti.
  - Leaving MAC: after tile (T-1,T-1) is written, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge e0; last tile written at edge e0 + T^3; done is high during the following cycle. For N = 4 that is 8 MAC cycles, with done high in cycle 9 after e0.
- start ignored while busy, including during DONE. Back-to-back operation costs one IDLE cycle.
- Tiles not yet rewritten keep the previous operation's values; the first tile updates at e0 + T.
- Arithmetic:
  - Each product is 4*width bits.
  - Accumulator is 4*width + clog2(N) bits, exact with no wrap.
  - Post-process: if shift > 0, add 1 << (shift-1) (round half up toward +inf), then arithmetic right shift by shift.
  - Saturate to the signed 2*width range [-2^(2w-1), 2^(2w-1)-1]. Any saturating element sets overflow.
- overflow holds until the next accepted start.
- A/B/shift changes after acceptance have no effect.

Optional Feature:
- Macro: MATRIX_TILED_ACC_EN.
- Defined:
  - Extra input acc_mode (1 bit), captured on start acceptance.
  - When acc_mode = 1, each written element = sat(C_old + rounded/shifted product). C_old is that element's C value before the write. The add is done at accumulator width before saturation.
  - overflow covers both the product and the sum.
- Not defined: no acc_mode port; behaviour is C = A x B only.

Test Plan:
- N=4, width=16, shift=0, A = identity, B[i][j] = 16*i+j, pulse start -> done high exactly 9 cycles after the accept edge; C = B; overflow = 0.
- All A = 2, all B = 3, shift = 0 -> every C = 24. Pulse start again while busy -> ignored; done still pulses only once.
- Rounding, shift = 1, only A[0][0] and B[0][0] nonzero: A[0][0]=3, B[0][0]=1 -> C[0][0] = 2. A[0][0] = -3 -> C[0][0] = -1. All other C = 0.
- Q16 scaling, shift = 16: A = identity * 32'h0001_0000, B all 32'h0001_8000 -> C all 32'h0001_8000.
- Saturation: A = B = all 32'h7FFF_FFFF, shift = 0 -> C all 32'h7FFF_FFFF, overflow = 1. Next run with small values -> overflow cleared at accept and stays 0.
- Reset mid-op: rst_n low during the 3rd MAC cycle -> C, busy, done, overflow all 0 asynchronously. After release, a fresh start completes correctly.

Source files
------------

// File: rtl/matrix_multi_tiled.sv
// matrix_multi_tiled: NxN signed fixed-point C = A x B on one reused 2x2 tile MAC with rounding, saturation and sticky overflow.
// Optional MATRIX_TILED_ACC_EN adds acc_mode, where each written element becomes sat(C_old + scaled product).
module matrix_multi_tiled #(
  parameter int width = 16,
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [N-1:0][N-1:0][2*width-1:0] A,
  input  logic [N-1:0][N-1:0][2*width-1:0] B,
  input  logic [4:0] shift,
`ifdef MATRIX_TILED_ACC_EN
  input  logic acc_mode,
`endif
  output logic busy,
  output logic done,
  output logic overflow,
  output logic [N-1:0][N-1:0][2*width-1:0] C
);
  localparam int T = N / 2;
  localparam int EW = 2 * width;
  localparam int PW = 4 * width;
  localparam int AW = PW + $clog2(N);
  localparam int TW = T > 1 ? $clog2(T) : 1;
  localparam logic signed [AW:0] MAXV = {{(AW + 2 - EW){1'b0}}, {(EW - 1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW + 2 - EW){1'b1}}, {(EW - 1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;
  state_t state, state_nxt;
  logic [N-1:0][N-1:0][EW-1:0] a_r, b_r;
  logic [4:0] sh_r;
  logic acc_r;
  logic [TW-1:0] ti, tj, k;
  logic signed [AW-1:0] acc [2][2];
  logic signed [AW-1:0] sum [2][2];
  logic [EW-1:0] res [2][2];
  logic sat [2][2];
  logic signed [PW-1:0] av, bv, pr;
  logic signed [AW:0] x, rnd;
  logic accept, k_last, tj_last, ti_last;
  assign accept = state == S_IDLE && start;
  assign k_last = k == TW'(T - 1);
  assign tj_last = tj == TW'(T - 1);
  assign ti_last = ti == TW'(T - 1);
`ifdef MATRIX_TILED_ACC_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_r <= 1'b0;
    else if (accept) acc_r <= acc_mode;
`else
  assign acc_r = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    busy = state != S_IDLE;
    done = state == S_DONE;
    state_nxt = state == S_IDLE ? (start ? S_MAC : S_IDLE)
              : state == S_MAC ? (k_last && tj_last && ti_last ? S_DONE : S_MAC)
              : S_IDLE;
  end
  // Tile (ti,tj) element (r,c) gathers the two products of block A(ti,k) x B(k,tj), then scales and clamps.
  always_comb begin
    av = '0;
    bv = '0;
    pr = '0;
    x = '0;
    rnd = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        sum[r][c] = acc[r][c];
        for (int m = 0; m < 2; m++) begin
          av = PW'($signed(a_r[{ti, 1'(r)}][{k, 1'(m)}]));
          bv = PW'($signed(b_r[{k, 1'(m)}][{tj, 1'(c)}]));
          pr = av * bv;
          sum[r][c] = sum[r][c] + AW'(pr);
        end
        x = {sum[r][c][AW-1], sum[r][c]};
        rnd = sh_r == 5'd0 ? '0 : (AW + 1)'(1) << (sh_r - 5'd1);
        x = (x + rnd) >>> sh_r;
        x = x + (acc_r ? (AW + 1)'($signed(C[{ti, 1'(r)}][{tj, 1'(c)}])) : '0);
        sat[r][c] = x > MAXV || x < MINV;
        res[r][c] = x > MAXV ? MAXV[EW-1:0] : x < MINV ? MINV[EW-1:0] : x[EW-1:0];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sh_r <= '0;
      ti <= '0;
      tj <= '0;
      k <= '0;
      overflow <= 1'b0;
      C <= '0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          acc[r][c] <= '0;
    end else if (accept) begin
      a_r <= A;
      b_r <= B;
      sh_r <= shift;
      ti <= '0;
      tj <= '0;
      k <= '0;
      overflow <= 1'b0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          acc[r][c] <= '0;
    end else if (state == S_MAC) begin
      k <= k_last ? '0 : k + TW'(1);
      if (k_last) begin
        tj <= tj_last ? '0 : tj + TW'(1);
        ti <= !tj_last ? ti : ti_last ? '0 : ti + TW'(1);
        overflow <= overflow | sat[0][0] | sat[0][1] | sat[1][0] | sat[1][1];
      end
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          acc[r][c] <= k_last ? '0 : sum[r][c];
          if (k_last) C[{ti, 1'(r)}][{tj, 1'(c)}] <= res[r][c];
        end
    end
endmodule

// File: tb/tb_matrix_multi_tiled.sv
// tb_matrix_multi_tiled: directed and randomized checks of matrix_multi_tiled against an untiled full-precision model.
module tb_matrix_multi_tiled;
  localparam int W = 16;
  localparam int N = 4;
  localparam int T = N / 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [4:0] shift = '0;
  logic [N-1:0][N-1:0][2*W-1:0] A = '0;
  logic [N-1:0][N-1:0][2*W-1:0] B = '0;
  logic [N-1:0][N-1:0][2*W-1:0] C;
  logic [N-1:0][N-1:0][2*W-1:0] exp_c = '0;
  logic [N-1:0][N-1:0][2*W-1:0] old_c = '0;
  logic exp_ov = 1'b0;
  logic busy, done, overflow;
`ifdef MATRIX_TILED_ACC_EN
  logic acc_mode = 1'b0;
`endif
  int compared = 0;
  int mismatched = 0;
  matrix_multi_tiled #(.width(W), .N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(A),
    .B(B),
    .shift(shift),
`ifdef MATRIX_TILED_ACC_EN
    .acc_mode(acc_mode),
`endif
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .C(C)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask
  // Full-precision reference: plain dot products, round half up, arithmetic shift, clamp to 32-bit signed.
  function automatic void model(input logic [4:0] sh);
    logic signed [127:0] s, a, b;
    exp_ov = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int m = 0; m < N; m++) begin
          a = $signed(A[i][m]);
          b = $signed(B[m][j]);
          s = s + a * b;
        end
        if (sh != 0) s = s + (128'sd1 <<< (sh - 1));
        s = s >>> sh;
        if (s > 128'sd2147483647) begin
          exp_c[i][j] = 32'h7fff_ffff;
          exp_ov = 1'b1;
        end else if (s < -128'sd2147483648) begin
          exp_c[i][j] = 32'h8000_0000;
          exp_ov = 1'b1;
        end else exp_c[i][j] = s[31:0];
      end
  endfunction
  task automatic check_c(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s C[%0d][%0d]", tag, i, j), 64'(C[i][j]), 64'(exp_c[i][j]));
    chk({tag, " overflow"}, 64'(overflow), 64'(exp_ov));
  endtask
  task automatic rand_fill(input bit big);
    logic [31:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        r = $urandom;
        A[i][j] = big ? r : {{16{r[15]}}, r[15:0]};
        r = $urandom;
        B[i][j] = big ? r : {{16{r[15]}}, r[15:0]};
      end
  endtask
  task automatic run_op(input string tag, input bit poke);
    int n;
    int extra;
    bit got;
    model(shift);
    old_c = C;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rand_fill(1'b1);
    shift = 5'($urandom);
    chk({tag, " busy after accept"}, 64'(busy), 64'd1);
    chk({tag, " overflow cleared at accept"}, 64'(overflow), 64'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == T) begin
        chk({tag, " first tile written"}, 64'(C[0][1]), 64'(exp_c[0][1]));
        chk({tag, " last tile still old"}, 64'(C[N-1][N-1]), 64'(old_c[N-1][N-1]));
      end
      if (poke) start = n == 3;
      got = done;
    end
    chk({tag, " done latency"}, 64'(n), 64'(T * T * T));
    check_c(tag);
    if (poke) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " done is one pulse"}, 64'(done), 64'd0);
    chk({tag, " idle after done"}, 64'(busy), 64'd0);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(posedge clk);
        #1;
        extra += int'(done);
      end
      chk({tag, " no extra done"}, 64'(extra), 64'd0);
      chk({tag, " still idle"}, 64'(busy), 64'd0);
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    exp_c = '0;
    exp_ov = 1'b0;
    check_c("reset");
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    A = '0;
    for (int i = 0; i < N; i++) A[i][i] = 32'd1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) B[i][j] = 32'(16 * i + j);
    shift = 5'd0;
    run_op("identity", 1'b0);
    chk("identity C[2][3]", 64'(C[2][3]), 64'd35);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 32'd2;
        B[i][j] = 32'd3;
      end
    shift = 5'd0;
    run_op("twos_threes", 1'b1);
    chk("twos_threes C[1][2]", 64'(C[1][2]), 64'd24);
    A = '0;
    B = '0;
    A[0][0] = 32'd3;
    B[0][0] = 32'd1;
    shift = 5'd1;
    run_op("round_pos", 1'b0);
    chk("round_pos C[0][0]", 64'(C[0][0]), 64'd2);
    A = '0;
    B = '0;
    A[0][0] = 32'hffff_fffd;
    B[0][0] = 32'd1;
    shift = 5'd1;
    run_op("round_neg", 1'b0);
    chk("round_neg C[0][0]", 64'(C[0][0]), 64'hffff_ffff);
    chk("round_neg C[1][1]", 64'(C[1][1]), 64'd0);
    A = '0;
    for (int i = 0; i < N; i++) A[i][i] = 32'h0001_0000;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) B[i][j] = 32'h0001_8000;
    shift = 5'd16;
    run_op("q16", 1'b0);
    chk("q16 C[2][1]", 64'(C[2][1]), 64'h0001_8000);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 32'h7fff_ffff;
        B[i][j] = 32'h7fff_ffff;
      end
    shift = 5'd0;
    run_op("saturate", 1'b0);
    chk("saturate C[3][0]", 64'(C[3][0]), 64'h7fff_ffff);
    chk("saturate overflow", 64'(overflow), 64'd1);
    rand_fill(1'b0);
    shift = 5'd4;
    run_op("after_sat", 1'b0);
    chk("after_sat overflow", 64'(overflow), 64'd0);
    rand_fill(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_c = '0;
    exp_ov = 1'b0;
    check_c("mid_reset");
    chk("mid_reset busy", 64'(busy), 64'd0);
    chk("mid_reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_fill(1'b0);
    shift = 5'd2;
    run_op("post_reset", 1'b0);
    for (int t = 0; t < 6; t++) begin
      rand_fill(t[0]);
      shift = t[0] ? 5'($urandom) : 5'($urandom_range(20));
      run_op($sformatf("random%0d", t), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
